// File: rtl/telemetry_tx.sv
// telemetry_tx: buffers one payload, computes its CRC32, then streams sync/header/CRC/payload.
// Build option TX_TRAILER_EN appends a single 8'h00 pad byte after the payload.
module telemetry_tx #(
  parameter int          MAX_PAYLOAD = 256,
  parameter logic [15:0] SYNC_WORD   = 16'hABCD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pkt_id,
  input  logic [31:0] line_number,
  input  logic [15:0] payload_size,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        size_err
);

  localparam int          AW       = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [16:0] MAX_SIZE = 17'(MAX_PAYLOAD);
  localparam logic [31:0] POLY     = 32'h04C11DB7;

`ifdef TX_TRAILER_EN
  typedef enum logic [2:0] {IDLE, LOAD, SYNC_HI, SYNC_LO, HEADER, PAYLOAD, TRAILER} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SYNC_HI, SYNC_LO, HEADER, PAYLOAD} state_t;
`endif

  state_t state, next_state;

  logic [15:0] pkt_id_q;
  logic [31:0] line_q;
  logic [15:0] size_q;
  logic [31:0] crc_q;
  logic [15:0] count;
  logic [3:0]  hdr_idx;
  logic [7:0]  pay_byte;
  logic [7:0]  mem [MAX_PAYLOAD];

  logic        done_next;
  logic        size_err_next;
  logic        start_take;
  logic        size_bad;
  logic        last_count;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [95:0] hdr_vec;
  logic [95:0] hdr_shift;
  logic [7:0]  hdr_byte;

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {b, 24'h000000};
    for (int i = 0; i < 8; i++) begin
      c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  // A start landing on the done pulse is not taken; a new packet begins the cycle after.
  assign start_take = (state == IDLE) && start && !done;
  assign size_bad   = (payload_size == 16'd0) || ({1'b0, payload_size} > MAX_SIZE);
  assign last_count = (count == size_q - 16'd1);
  assign wr_addr    = count[AW-1:0];
  assign rd_addr    = AW'(count + 16'd1);
  assign busy       = (state != IDLE);

  assign hdr_vec   = {pkt_id_q, line_q, size_q, ~crc_q};
  assign hdr_shift = hdr_vec << {hdr_idx, 3'b000};
  assign hdr_byte  = hdr_shift[95:88];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      size_err <= 1'b0;
    end else begin
      state    <= next_state;
      done     <= done_next;
      size_err <= size_err_next;
    end
  end

  always_comb begin
    next_state    = state;
    done_next     = 1'b0;
    size_err_next = 1'b0;
    in_ready      = 1'b0;
    tx_valid      = 1'b0;
    tx_byte       = 8'h00;
    case (state)
      IDLE: begin
        if (start_take) begin
          if (size_bad) size_err_next = 1'b1;
          else          next_state    = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_count) next_state = SYNC_HI;
      end
      SYNC_HI: begin
        tx_valid = 1'b1;
        tx_byte  = SYNC_WORD[15:8];
        if (tx_ready) next_state = SYNC_LO;
      end
      SYNC_LO: begin
        tx_valid = 1'b1;
        tx_byte  = SYNC_WORD[7:0];
        if (tx_ready) next_state = HEADER;
      end
      HEADER: begin
        tx_valid = 1'b1;
        tx_byte  = hdr_byte;
        if (tx_ready && hdr_idx == 4'd11) next_state = PAYLOAD;
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        tx_byte  = pay_byte;
        if (tx_ready && last_count) begin
`ifdef TX_TRAILER_EN
          next_state = TRAILER;
`else
          next_state = IDLE;
          done_next  = 1'b1;
`endif
        end
      end
`ifdef TX_TRAILER_EN
      TRAILER: begin
        tx_valid = 1'b1;
        tx_byte  = 8'h00;
        if (tx_ready) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // count indexes the buffer while loading, then is reused as the payload read index.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_id_q <= 16'h0000;
      line_q   <= 32'h00000000;
      size_q   <= 16'h0000;
      crc_q    <= 32'h00000000;
      count    <= 16'h0000;
      hdr_idx  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_take && !size_bad) begin
            pkt_id_q <= pkt_id;
            line_q   <= line_number;
            size_q   <= payload_size;
            crc_q    <= 32'hFFFFFFFF;
            count    <= 16'h0000;
            hdr_idx  <= 4'd0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            crc_q <= crc_byte(crc_q, in_byte);
            count <= last_count ? 16'h0000 : count + 16'd1;
          end
        end
        HEADER: begin
          if (tx_ready) hdr_idx <= (hdr_idx == 4'd11) ? 4'd0 : hdr_idx + 4'd1;
        end
        PAYLOAD: begin
          if (tx_ready) count <= count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // pay_byte always holds the byte to present next, so payload bytes stream without bubbles.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) mem[wr_addr] <= in_byte;
    if (state == HEADER)                      pay_byte <= mem['0];
    else if (state == PAYLOAD && tx_ready)    pay_byte <= mem[rd_addr];
  end

endmodule

// File: tb/tb_telemetry_tx.sv
// Self-checking bench for telemetry_tx: scoreboard of expected frame bytes plus directed steps.
module tb_telemetry_tx;

  localparam int MAXP = 256;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] pkt_id;
  logic [31:0] line_number;
  logic [15:0] payload_size;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        size_err;

  telemetry_tx #(.MAX_PAYLOAD(MAXP), .SYNC_WORD(16'hABCD)) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_id(pkt_id), .line_number(line_number),
    .payload_size(payload_size), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
    .size_err(size_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_seen = 0;
  bit          rand_ready = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  pl[$];
  logic [7:0]  exp_byte;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;
  bit          frame_active = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Bit-serial reference CRC: init all-ones, MSB first, no reflection.
  function automatic logic [31:0] crcModel(input logic [7:0] data[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    logic fb;
    foreach (data[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[31] ^ data[i][b];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h00000000);
      end
    end
    return c;
  endfunction

  task automatic pushFrame(input logic [15:0] id, input logic [31:0] ln, input logic [7:0] data[$]);
    logic [31:0] c;
    logic [15:0] sz;
    c  = ~crcModel(data);
    sz = 16'(data.size());
    exp_q.push_back(8'hAB);     exp_q.push_back(8'hCD);
    exp_q.push_back(id[15:8]);  exp_q.push_back(id[7:0]);
    exp_q.push_back(ln[31:24]); exp_q.push_back(ln[23:16]);
    exp_q.push_back(ln[15:8]);  exp_q.push_back(ln[7:0]);
    exp_q.push_back(sz[15:8]);  exp_q.push_back(sz[7:0]);
    exp_q.push_back(c[31:24]);  exp_q.push_back(c[23:16]);
    exp_q.push_back(c[15:8]);   exp_q.push_back(c[7:0]);
    foreach (data[i]) exp_q.push_back(data[i]);
`ifdef TX_TRAILER_EN
    exp_q.push_back(8'h00);
`endif
  endtask

  // Issues start, loads the payload, and checks the first sync byte follows the last beat directly.
  task automatic applyStimulus(input logic [15:0] id, input logic [31:0] ln, input logic [7:0] data[$]);
    int guard;
    done_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; pkt_id = id; line_number = ln; payload_size = 16'(data.size());
    @(posedge clk); #1;
    start = 1'b0;
    foreach (data[i]) begin
      in_byte  = data[i];
      in_valid = 1'b1;
      guard    = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
        guard++;
        @(negedge clk);
      end
      if (!in_ready) checkOutput("in_ready_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("first_valid_latency", tx_valid, 1);
    checkOutput("first_byte", tx_byte, 8'hAB);
  endtask

  task automatic waitDone(input string tag);
    int guard = 0;
    while (!done && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_done_once"}, done_seen, 1);
    checkOutput({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic sizeReject(input logic [15:0] sz);
    @(posedge clk); #1;
    start = 1'b1; payload_size = sz;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("size_err_pulse", size_err, 1);
    checkOutput("size_err_busy", busy, 0);
    checkOutput("size_err_tx_valid", tx_valid, 0);
    @(negedge clk);
    checkOutput("size_err_clears", size_err, 0);
    checkOutput("size_err_idle", busy, 0);
  endtask

  // Downstream ready: either tied high or toggled pseudo-randomly each cycle.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold-while-stalled and no gaps.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall   = 1'b0;
        frame_active = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("hold_valid", tx_valid, 1);
          checkOutput("hold_byte", tx_byte, prev_byte);
        end
        if (tx_valid) frame_active = 1'b1;
        else if (frame_active && !done) begin
          checkOutput("no_gap", tx_valid, 1);
          frame_active = 1'b0;
        end
        if (done) begin
          done_seen++;
          frame_active = 1'b0;
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) checkOutput("unexpected_byte", tx_valid, 0);
          else begin
            exp_byte = exp_q.pop_front();
            checkOutput("tx_byte", tx_byte, exp_byte);
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = tx_byte;
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pkt_id = '0; line_number = '0; payload_size = '0;
    in_byte = '0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tx_valid", tx_valid, 0);
    checkOutput("reset_tx_byte", tx_byte, 8'h00);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_size_err", size_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] reference packet, ready tied high");
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp_q = '{8'hAB, 8'hCD, 8'h01, 8'h02, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00, 8'h09,
              8'hFC, 8'h89, 8'h19, 8'h18,
              8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
`ifdef TX_TRAILER_EN
    exp_q.push_back(8'h00);
`endif
    rand_ready = 1'b0;
    applyStimulus(16'h0102, 32'h0A0B0C0D, pl);
    waitDone("ref_tied");

    $display("[TB] reference packet, random ready");
    rand_ready = 1'b1;
    pushFrame(16'h0102, 32'h0A0B0C0D, pl);
    applyStimulus(16'h0102, 32'h0A0B0C0D, pl);
    waitDone("ref_random");
    rand_ready = 1'b0;

    $display("[TB] illegal sizes");
    sizeReject(16'd0);
    sizeReject(16'(MAXP + 1));

    $display("[TB] full-size payload");
    pl.delete();
    for (int i = 0; i < MAXP; i++) pl.push_back(8'(i));
    rand_ready = 1'b1;
    pushFrame(16'hBEEF, 32'h12345678, pl);
    applyStimulus(16'hBEEF, 32'h12345678, pl);
    waitDone("full");
    rand_ready = 1'b0;

    $display("[TB] single-byte payload");
    pl = '{8'h00};
    pushFrame(16'h0007, 32'h00000001, pl);
    applyStimulus(16'h0007, 32'h00000001, pl);
    waitDone("single");

    $display("[TB] start during header, in_valid during payload");
    pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    pushFrame(16'h5A5A, 32'hCAFEF00D, pl);
    applyStimulus(16'h5A5A, 32'hCAFEF00D, pl);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; payload_size = 16'd0; pkt_id = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("busy_start_no_size_err", size_err, 0);
    checkOutput("busy_start_still_busy", busy, 1);
    in_byte = 8'hEE; in_valid = 1'b1;
    waitDone("ignored_inputs");
    in_valid = 1'b0;

    $display("[TB] reset mid-payload");
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'(8'h80 + i));
    pushFrame(16'h1111, 32'h22222222, pl);
    applyStimulus(16'h1111, 32'h22222222, pl);
    repeat (18) @(posedge clk);
    #1;
    checkOutput("abort_in_payload", tx_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_tx_valid", tx_valid, 0);
    checkOutput("abort_tx_byte", tx_byte, 8'h00);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_in_ready", in_ready, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_size_err", size_err, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] packet after abort");
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03};
    rand_ready = 1'b1;
    pushFrame(16'h2222, 32'h00C0FFEE, pl);
    applyStimulus(16'h2222, 32'h00C0FFEE, pl);
    waitDone("post_abort");
    rand_ready = 1'b0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/telemetry_tx.md
Name: telemetry_tx

Overview:
Packet framer and transmitter for the telemetry link. It accepts a header (packet ID, line number, payload size) and a payload byte stream, and buffers the whole payload so the CRC32 can be computed first. It then emits the framed byte stream to the serializer: sync, header, CRC, payload and an optional trailer. It sits on the sending side of the link, feeding the byte-wide UART/serializer front end.

Parameters:
MAX_PAYLOAD, 256, payload buffer depth in bytes; legal payload_size range is 1..MAX_PAYLOAD.
SYNC_WORD, 16'hABCD, frame sync word, sent MSB byte first.

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
start  input  1  one-cycle request to begin a packet; sampled only in IDLE
pkt_id  input  16  packet ID; latched on accepted start
line_number  input  32  line number; latched on accepted start
payload_size  input  16  payload length in bytes; latched on accepted start
in_byte  input  8  payload data byte
in_valid  input  1  in_byte valid
in_ready  output  1  block accepts a payload byte; high only in LOAD
tx_byte  output  8  framed output byte
tx_valid  output  1  tx_byte valid
tx_ready  input  1  downstream accepts tx_byte
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last byte of a packet is accepted
size_err  output  1  one-cycle pulse when start is rejected for an illegal size

Behaviour:
- Reset: state IDLE. tx_valid, in_ready, busy, done and size_err are 0; tx_byte is 8'h00. Latched header and CRC registers are cleared. Buffered payload is discarded.
- Reset is effective in every state. A packet in progress is aborted, and tx_valid drops the cycle after rst is sampled.
- IDLE, on start:
  - If payload_size is 0 or greater than MAX_PAYLOAD: pulse size_err next cycle and stay in IDLE.
  - Otherwise: latch the header fields, set CRC to 32'hFFFFFFFF, clear the byte counter and go to LOAD.
- LOAD: in_ready is 1. Each in_valid & in_ready beat does three things:
  - writes in_byte to buffer[count];
  - updates CRC (see below);
  - increments count.
- LOAD exit: after the beat where count == payload_size-1, in_ready goes low and the state moves to SYNC_HI. The first tx_valid (0xAB) appears the cycle after that final beat.
- CRC32: polynomial 32'h04C11DB7, MSB-first, non-reflected.
  - Per byte: c ^= byte<<24, then 8 shift/xor steps.
  - The transmitted field is the bitwise inverse of the final register.
  - The CRC covers payload bytes only.
- Transmit order, one byte per tx_valid & tx_ready handshake:
  - SYNC_HI: SYNC_WORD[15:8]. SYNC_LO: SYNC_WORD[7:0].
  - HEADER, 12 bytes, big-endian: pkt_id (2 bytes), line_number (4), payload_size (2), ~crc (4).
  - PAYLOAD: buffer[0..payload_size-1].
  - TRAILER (optional, see below).
- Handshake rules:
  - While tx_valid & !tx_ready, tx_byte and tx_valid hold stable.
  - tx_valid does not deassert between the first sync byte and the last byte of the packet. No bubbles are permitted, including across buffer reads (prefetch required).
- Completion: after the final byte handshake, done pulses for 1 cycle, busy drops the same cycle and the state returns to IDLE. A new start is accepted from the cycle after done.
- Simultaneous events: start while busy is ignored with no size_err. in_valid outside LOAD is ignored.

Optional Feature:
TX_TRAILER_EN:
- Defined: after the last payload byte, a TRAILER state emits one 8'h00 pad byte before done. This clocks the far-end receiver's CRC-check state, so its packet-valid flag asserts without waiting for the next frame.
- Undefined: the TRAILER state is absent and done follows the last payload byte.

Test Plan:
- Send pkt_id 0x0102, line 0x0A0B0C0D, payload 0x31..0x39 ("123456789"), tx_ready tied 1 -> output is AB CD 01 02 0A 0B 0C 0D 00 09 FC 89 19 18 31..39 (+00 with TX_TRAILER_EN). Output must have no gaps and done must pulse once.
- Same packet with tx_ready toggling pseudo-randomly -> identical byte sequence, and tx_byte stays stable whenever tx_valid & !tx_ready.
- payload_size 0, then payload_size MAX_PAYLOAD+1 -> size_err pulses each time, busy stays 0 and no tx_valid. Then payload_size MAX_PAYLOAD with bytes 0x00,0x01,... -> full buffer is emitted with the correct CRC.
- Single-byte payload 0x00 -> size field 00 01 and CRC field equals the inverted CRC of one 0x00 byte (checked against the bench model). The first tx_valid occurs 1 cycle after the in_valid beat.
- start asserted during HEADER and in_valid asserted during PAYLOAD -> both ignored; the frame is unaltered.
- rst asserted mid-PAYLOAD -> tx_valid is 0 the next cycle and all outputs are at reset values. A following packet is transmitted correctly, with no residue from the aborted one.
